// File: rtl/sd_tagdemux_pkg.sv
// rtl/sd_tagdemux_pkg.sv - shared constants and helpers for the tag demux
// Counter width applies when SD_TAGDEMUX_COUNT_EN is defined.
package sd_tagdemux_pkg;

  localparam int CNT_W = 16;
  // Widest data word the helpers below accept.
  localparam int MAX_W = 256;

  function automatic int unsigned tag_of(input logic [MAX_W-1:0] data,
                                         input int width,
                                         input int tag_sz);
    logic [MAX_W-1:0] sh;
    sh = data >> (width - tag_sz);
    return 32'(sh) & ((32'd1 << tag_sz) - 32'd1);
  endfunction

  // All ones when passing data through; otherwise clears the tag field.
  function automatic logic [MAX_W-1:0] strip_mask(input int width,
                                                  input int tag_sz,
                                                  input int strip);
    logic [MAX_W-1:0] m;
    m = '1;
    if (strip != 0) m = (MAX_W'(1) << (width - tag_sz)) - MAX_W'(1);
    return m;
  endfunction

endpackage

// File: rtl/sd_tagdemux_slot.sv
// rtl/sd_tagdemux_slot.sv - one-word holding register for a single output port
// A load always wins over a drain, so a simultaneous drain and fill keeps the slot full.
module sd_tagdemux_slot #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] data,
  input  logic             p_drdy,
  output logic             p_srdy,
  output logic [width-1:0] p_data,
  output logic             ready
);

  logic full;

  always_ff @(posedge clk) begin
    if (reset) begin
      full   <= 1'b0;
      p_data <= '0;
    end else if (load) begin
      full   <= 1'b1;
      p_data <= data;
    end else if (p_drdy) begin
      full   <= 1'b0;
    end
  end

  assign p_srdy = full;
  assign ready  = ~full | p_drdy;

endmodule

// File: rtl/sd_tagdemux.sv
// rtl/sd_tagdemux.sv - tag-steered one-to-many srdy/drdy demux with per-port holding slots
// Optional per-port and drop counters: SD_TAGDEMUX_COUNT_EN
module sd_tagdemux
  import sd_tagdemux_pkg::*;
#(
  parameter int width   = 8,
  parameter int outputs = 4,
  parameter int tag_sz  = 2,
  parameter int strip   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     c_srdy,
  output logic                     c_drdy,
  input  logic [width-1:0]         c_data,
  output logic                     c_err,
  output logic [outputs-1:0]       p_srdy,
  input  logic [outputs-1:0]       p_drdy,
  output logic [outputs*width-1:0] p_data
`ifdef SD_TAGDEMUX_COUNT_EN
  ,
  output logic [outputs*CNT_W-1:0] cnt_out,
  output logic [CNT_W-1:0]         cnt_drop
`endif
);

  localparam logic [MAX_W-1:0] STRIP_M = strip_mask(width, tag_sz, strip);

  int unsigned        tag;
  logic               tag_ok;
  logic               tgt_ready;
  logic               drop;
  logic [width-1:0]   word;
  logic [outputs-1:0] load;
  logic [outputs-1:0] ready;

  assign tag    = tag_of(MAX_W'(c_data), width, tag_sz);
  assign tag_ok = tag < unsigned'(outputs);
  assign word   = c_data & STRIP_M[width-1:0];

  // Only the addressed slot's ready is consulted; decode is gated by c_srdy.
  always_comb begin
    tgt_ready = 1'b0;
    load      = '0;
    for (int k = 0; k < outputs; k++) begin
      if (c_srdy && tag == unsigned'(k)) begin
        tgt_ready = ready[k];
        load[k]   = ~reset & ready[k];
      end
    end
  end

  assign c_drdy = ~reset & c_srdy & (tgt_ready | ~tag_ok);
  assign drop   = c_drdy & ~tag_ok;

  always_ff @(posedge clk) begin
    if (reset) c_err <= 1'b0;
    else       c_err <= drop;
  end

  for (genvar k = 0; k < outputs; k++) begin : g_slot
    sd_tagdemux_slot #(.width(width)) u_slot (
      .clk    (clk),
      .reset  (reset),
      .load   (load[k]),
      .data   (word),
      .p_drdy (p_drdy[k]),
      .p_srdy (p_srdy[k]),
      .p_data (p_data[k*width +: width]),
      .ready  (ready[k])
    );
  end

`ifdef SD_TAGDEMUX_COUNT_EN
  for (genvar k = 0; k < outputs; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset)                      cnt <= '0;
      else if (p_srdy[k] & p_drdy[k]) cnt <= cnt + CNT_W'(1);
    end

    assign cnt_out[k*CNT_W +: CNT_W] = cnt;
  end

  always_ff @(posedge clk) begin
    if (reset)     cnt_drop <= '0;
    else if (drop) cnt_drop <= cnt_drop + CNT_W'(1);
  end
`endif

endmodule
